// File: rtl/paddle_controller.sv
// Paddle position controller: synchronises and debounces two normally-closed buttons,
// then drives a saturating paddle position through a three-state motion FSM.
module paddle_controller #(
   parameter int POS_W    = 9,
   parameter int POS_MIN  = 0,
   parameter int POS_MAX  = 400,
   parameter int POS_INIT = 200,
   parameter int STEP     = 1,
   parameter int DB_COUNT = 50000,
   parameter int TICK_DIV = 1048576
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             buttonLeft,
   input  logic             buttonRight,
   output logic [POS_W-1:0] location,
   output logic             leftPressed,
   output logic             rightPressed,
   output logic             atMin,
   output logic             atMax
);

   localparam int DB_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   // Moving left raises the position; the sum is formed one bit wider so it cannot wrap.
   function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] pos);
      logic [POS_W:0] sum;
      sum = {1'b0, pos} + (POS_W+1)'(STEP);
      if (sum > (POS_W+1)'(POS_MAX))
         return POS_W'(POS_MAX);
      return sum[POS_W-1:0];
   endfunction

   function automatic logic [POS_W-1:0] sat_dec(input logic [POS_W-1:0] pos);
      if ({1'b0, pos} < (POS_W+1)'(POS_MIN + STEP))
         return POS_W'(POS_MIN);
      return pos - POS_W'(STEP);
   endfunction

   // Bit 0 carries the left button, bit 1 the right button throughout.
   logic [1:0]        sync_p0;
   logic [1:0]        sync_p1;
   logic [1:0]        press_raw;
   logic [1:0]        flag;
   logic [DB_W-1:0]   db_cnt [2];

   state_t            state;
   state_t            state_nxt;
   logic [TICK_W-1:0] tick;
   logic [TICK_W-1:0] tick_nxt;
   logic              move_left;
   logic              move_right;

   // ---- stage p0/p1: two-flop synchroniser, released (1) out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 2'b11;
         sync_p1 <= 2'b11;
      end else begin
         sync_p0 <= {buttonRight, buttonLeft};
         sync_p1 <= sync_p0;
      end
   end

   assign press_raw = ~sync_p1;

   // ---- debounce: a change must persist DB_COUNT cycles before the flag follows it
   always_ff @(posedge clk) begin
      if (reset) begin
         flag <= 2'b00;
         for (int i = 0; i < 2; i++)
            db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (press_raw[i] == flag[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DB_COUNT - 1)) begin
               flag[i]   <= press_raw[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign leftPressed  = flag[0];
   assign rightPressed = flag[1];

   // ---- motion FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tick  <= '0;
      end else begin
         state <= state_nxt;
         tick  <= tick_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tick_nxt   = '0;
      move_left  = 1'b0;
      move_right = 1'b0;
      case (state)
         IDLE: begin
            if (leftPressed && !rightPressed) begin
               state_nxt = LEFT;
               move_left = 1'b1;
            end else if (rightPressed && !leftPressed) begin
               state_nxt  = RIGHT;
               move_right = 1'b1;
            end
         end
         LEFT: begin
            if (!leftPressed || rightPressed) begin
               state_nxt = IDLE;
            end else if (tick == TICK_W'(TICK_DIV - 1)) begin
               move_left = 1'b1;
            end else begin
               tick_nxt = tick + TICK_W'(1);
            end
         end
         RIGHT: begin
            if (!rightPressed || leftPressed) begin
               state_nxt = IDLE;
            end else if (tick == TICK_W'(TICK_DIV - 1)) begin
               move_right = 1'b1;
            end else begin
               tick_nxt = tick + TICK_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- position register, saturating at both limits
   always_ff @(posedge clk) begin
      if (reset)
         location <= POS_W'(POS_INIT);
      else if (move_left)
         location <= sat_inc(location);
      else if (move_right)
         location <= sat_dec(location);
   end

   assign atMin = (location == POS_W'(POS_MIN));
   assign atMax = (location == POS_W'(POS_MAX));

endmodule
